// File: rtl/castle_pan_ramp_if.sv
// Pan-stage bus: CPU pan write, mono sample input, and the registered stereo outputs.
interface castle_pan_ramp_if #(parameter int unsigned W = 16);
  logic                pan_we;
  logic [2:0]          pan_din;
  logic                sample;
  logic signed [W-1:0] snd_in;
  logic signed [W-1:0] left;
  logic signed [W-1:0] right;
  logic                sample_out;
  logic                busy;
  logic [2:0]          pan_cur;

  modport master (
    output pan_we, pan_din, sample, snd_in,
    input  left, right, sample_out, busy, pan_cur
  );

  modport slave (
    input  pan_we, pan_din, sample, snd_in,
    output left, right, sample_out, busy, pan_cur
  );
endinterface

// File: rtl/castle_pan_ramp.sv
// Stereo pan stage: splits a mono sample into L/R using quarter-unit gains that
// ramp one step per sample toward the targets decoded from the CPU pan code.
module castle_pan_ramp #(
  parameter int unsigned W = 16
) (
  input logic               clk,
  input logic               rst_n,
  castle_pan_ramp_if.slave  bus
);

  localparam int unsigned GW = 3;
  localparam int unsigned PW = W + 4;

  typedef enum logic {IDLE, RAMP} state_t;

  state_t              state, state_n;
  logic [GW-1:0]       gl, gr, tl, tr;
  logic [GW-1:0]       gl_n, gr_n, tl_n, tr_n;
  logic [2:0]          pan_cur, pan_cur_n;
  logic signed [W-1:0] left, right, left_n, right_n;
  logic                sample_out, sample_out_n;
  logic                busy, busy_n;
  logic signed [PW-1:0] prod_l, prod_r;

  // Pan code to (L,R) target gains in quarter units.
  function automatic logic [2*GW-1:0] pan_map(input logic [2:0] code);
    logic [2*GW-1:0] m;
    case (code)
      3'd0:    m = {3'd4, 3'd0};
      3'd1:    m = {3'd4, 3'd1};
      3'd2:    m = {3'd4, 3'd2};
      3'd3:    m = {3'd4, 3'd3};
      3'd4:    m = {3'd4, 3'd4};
      3'd5:    m = {3'd3, 3'd4};
      3'd6:    m = {3'd2, 3'd4};
      default: m = {3'd1, 3'd4};
    endcase
    return m;
  endfunction

  function automatic logic [GW-1:0] step_to(input logic [GW-1:0] g, input logic [GW-1:0] t);
    logic [GW-1:0] r;
    r = g;
    if (g < t)      r = g + GW'(1);
    else if (g > t) r = g - GW'(1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gl         <= GW'(4);
      gr         <= GW'(4);
      tl         <= GW'(4);
      tr         <= GW'(4);
      pan_cur    <= 3'd4;
      left       <= '0;
      right      <= '0;
      sample_out <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      gl         <= gl_n;
      gr         <= gr_n;
      tl         <= tl_n;
      tr         <= tr_n;
      pan_cur    <= pan_cur_n;
      left       <= left_n;
      right      <= right_n;
      sample_out <= sample_out_n;
      busy       <= busy_n;
    end
  end

  // Next-state: a write retargets first, so a same-cycle strobe already steps toward the new target.
  always_comb begin
    state_n      = state;
    gl_n         = gl;
    gr_n         = gr;
    tl_n         = tl;
    tr_n         = tr;
    pan_cur_n    = pan_cur;
    left_n       = left;
    right_n      = right;
    sample_out_n = 1'b0;
    busy_n       = busy;

    // Products always use the gains held before this strobe's step.
    prod_l = PW'(bus.snd_in) * PW'($signed({1'b0, gl}));
    prod_r = PW'(bus.snd_in) * PW'($signed({1'b0, gr}));

    if (bus.pan_we) begin
      pan_cur_n    = bus.pan_din;
      {tl_n, tr_n} = pan_map(bus.pan_din);
    end

    if (bus.sample) begin
      gl_n         = step_to(gl, tl_n);
      gr_n         = step_to(gr, tr_n);
      left_n       = W'(prod_l >>> 2);
      right_n      = W'(prod_r >>> 2);
      sample_out_n = 1'b1;
    end

    case (state)
      IDLE:    if (gl_n != tl_n || gr_n != tr_n) state_n = RAMP;
      RAMP:    if (gl_n == tl_n && gr_n == tr_n) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RAMP);
  end

  assign bus.left       = left;
  assign bus.right      = right;
  assign bus.sample_out = sample_out;
  assign bus.busy       = busy;
  assign bus.pan_cur    = pan_cur;

endmodule

// File: tb/tb_castle_pan_ramp.sv
// Directed bench for castle_pan_ramp with hand-computed expected outputs.
module tb_castle_pan_ramp;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  castle_pan_ramp_if #(.W(W)) bus ();

  castle_pan_ramp #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.pan_we  = 1'b0;
    bus.sample  = 1'b0;
    bus.pan_din = '0;
    bus.snd_in  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input int code);
    @(negedge clk);
    bus.pan_we  = 1'b1;
    bus.pan_din = 3'(code);
    @(negedge clk);
    bus.pan_we  = 1'b0;
  endtask

  // One strobe (optionally with a same-cycle write), then check the registered result.
  task automatic strobe(input string tag, input int val, input bit with_wr, input int code,
                        input int exp_l, input int exp_r);
    @(negedge clk);
    bus.sample  = 1'b1;
    bus.snd_in  = W'(val);
    bus.pan_we  = with_wr;
    bus.pan_din = 3'(code);
    @(negedge clk);
    bus.sample  = 1'b0;
    bus.pan_we  = 1'b0;
    check({tag, ".left"},  int'(bus.left),  exp_l);
    check({tag, ".right"}, int'(bus.right), exp_r);
    check({tag, ".sout"},  int'(bus.sample_out), 1);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.pan_we  = 1'b0;
    bus.pan_din = '0;
    bus.sample  = 1'b0;
    bus.snd_in  = '0;
    repeat (3) @(negedge clk);

    check("rst.left",    int'(bus.left), 0);
    check("rst.right",   int'(bus.right), 0);
    check("rst.busy",    int'(bus.busy), 0);
    check("rst.sout",    int'(bus.sample_out), 0);
    check("rst.pan_cur", int'(bus.pan_cur), 4);
    rst_n = 1'b1;
    strobe("center", 1000, 1'b0, 0, 1000, 1000);
    @(negedge clk);
    check("center.sout_pulse", int'(bus.sample_out), 0);

    // Hard pan left: right gain 4->0, product uses pre-step gain.
    wr(0);
    check("hard.busy0",   int'(bus.busy), 1);
    check("hard.pan_cur", int'(bus.pan_cur), 0);
    strobe("hard1", 1000, 1'b0, 0, 1000, 1000);
    strobe("hard2", 1000, 1'b0, 0, 1000, 750);
    strobe("hard3", 1000, 1'b0, 0, 1000, 500);
    check("hard.busy3", int'(bus.busy), 1);
    strobe("hard4", 1000, 1'b0, 0, 1000, 250);
    check("hard.busy4", int'(bus.busy), 0);
    strobe("hard5", 1000, 1'b0, 0, 1000, 0);

    // Mid-ramp reversal: gr 4->3->2, then code 7 sends gl to 1 and gr back to 4.
    do_reset();
    wr(0);
    strobe("rev1", 1000, 1'b0, 0, 1000, 1000);
    strobe("rev2", 1000, 1'b0, 0, 1000, 750);
    wr(7);
    check("rev.pan_cur", int'(bus.pan_cur), 7);
    strobe("rev3", 1000, 1'b0, 0, 1000, 500);
    strobe("rev4", 1000, 1'b0, 0, 750, 750);
    check("rev.busy4", int'(bus.busy), 1);
    strobe("rev5", 1000, 1'b0, 0, 500, 1000);
    check("rev.busy5", int'(bus.busy), 0);
    strobe("rev6", 1000, 1'b0, 0, 250, 1000);

    // Write and strobe in the same cycle.
    do_reset();
    strobe("sim1", -800, 1'b1, 6, -800, -800);
    check("sim.busy", int'(bus.busy), 1);
    strobe("sim2", -800, 1'b0, 0, -600, -800);

    // Full-scale extremes at gain 4 and gain 1.
    do_reset();
    strobe("ext4n", -32768, 1'b0, 0, -32768, -32768);
    strobe("ext4p", 32767, 1'b0, 0, 32767, 32767);
    wr(7);
    strobe("ramp_a", 0, 1'b0, 0, 0, 0);
    strobe("ramp_b", 0, 1'b0, 0, 0, 0);
    strobe("ramp_c", 0, 1'b0, 0, 0, 0);
    strobe("ext1n", -32768, 1'b0, 0, -8192, -32768);
    strobe("ext1p", 32767, 1'b0, 0, 8191, 32767);

    // Reset while ramping toward hard left.
    wr(0);
    strobe("mr1", 1000, 1'b0, 0, 250, 1000);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr.busy",    int'(bus.busy), 0);
    check("mr.pan_cur", int'(bus.pan_cur), 4);
    check("mr.left",    int'(bus.left), 0);
    rst_n = 1'b1;
    strobe("mr2", 1000, 1'b0, 0, 1000, 1000);
    check("mr.busy2", int'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
